// File: rtl/ifq_fetch_ctrl.sv
// Instruction fetch queue: fetches I-cache lines, unpacks them one word per cycle into a
// show-ahead FIFO and handles branch redirects. Define IFQ_BYPASS_EN to forward words when empty.
module ifq_fetch_ctrl #(
    parameter int unsigned       INST_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       LINE_INSTS = 4,
    parameter int unsigned       DEPTH      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         cache_en,
    output logic [ADDR_W-1:0]            cache_addr,
    input  logic                         cache_dout_valid,
    input  logic [LINE_INSTS*INST_W-1:0] cache_dout,
    input  logic                         branch_valid,
    input  logic [ADDR_W-1:0]            branch_target,
    input  logic                         rd_enable,
    output logic [INST_W-1:0]            dout,
    output logic [ADDR_W-1:0]            dout_pc,
    output logic                         dout_valid,
    output logic                         fifo_empty,
    output logic                         fifo_full
);
    localparam int unsigned BYTES   = INST_W / 8;
    localparam int unsigned OFF_LSB = $clog2(BYTES);
    localparam int unsigned IDX_W   = $clog2(LINE_INSTS);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_INSTS * BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(BYTES);
    localparam logic [CNT_W-1:0]  CNT_ROOM  = CNT_W'(DEPTH - LINE_INSTS);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(LINE_INSTS - 1);

    typedef enum logic [2:0] {
        StRst,
        StIdle,
        StReq,
        StUnpack,
        StDrain
    } state_e;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]            pc_q, pc_d;
    logic [LINE_INSTS*INST_W-1:0] line_q, line_d;

    logic [INST_W-1:0] mem_inst_q [DEPTH];
    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];

    logic [INST_W-1:0] line_words [LINE_INSTS];
    logic [IDX_W-1:0]  idx;
    logic [INST_W-1:0] unpack_word;
    logic              unpacking;
    logic              bypass;
    logic              fifo_valid;
    logic              push;
    logic              push_en;
    logic              pop;

    always_comb begin
        for (int i = 0; i < LINE_INSTS; i++) begin
            line_words[i] = line_q[i*INST_W +: INST_W];
        end
    end

    // The word index within the line is simply the offset field of the fetch PC.
    assign idx         = pc_q[OFF_LSB +: IDX_W];
    assign unpack_word = line_words[idx];
    assign unpacking   = (state_q == StUnpack);
    assign fifo_valid  = (count_q != '0);

`ifdef IFQ_BYPASS_EN
    assign bypass = unpacking && !fifo_valid;
`else
    assign bypass = 1'b0;
`endif

    assign pop     = rd_enable && fifo_valid;
    assign push    = unpacking && !(bypass && rd_enable);
    assign push_en = push && !branch_valid;

    assign dout       = bypass ? unpack_word : mem_inst_q[rd_ptr_q];
    assign dout_pc    = bypass ? pc_q : mem_pc_q[rd_ptr_q];
    assign dout_valid = fifo_valid || bypass;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign cache_addr = pc_q & ~LINE_MASK;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        pc_d     = pc_q;
        line_d   = line_q;
        cache_en = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            StRst: state_d = StIdle;
            StIdle: begin
                if (count_q <= CNT_ROOM) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                cache_en = 1'b1;
                if (cache_dout_valid) begin
                    line_d  = cache_dout;
                    state_d = StUnpack;
                end
            end
            StUnpack: begin
                pc_d = pc_q + PC_STEP;
                if (idx == IDX_LAST) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (cache_dout_valid) begin
                    state_d = StReq;
                end
            end
            default: state_d = StRst;
        endcase

        // A response coinciding with the redirect is the one being drained; a DRAIN that is
        // still waiting keeps waiting so its stale response is never taken as the new line.
        if (branch_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = branch_target;
            if ((state_q == StReq || state_q == StDrain) && !cache_dout_valid) begin
                state_d = StDrain;
            end else begin
                state_d = StReq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRst;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            pc_q     <= RESET_PC;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            pc_q     <= pc_d;
            line_q   <= line_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_inst_q[wr_ptr_q] <= unpack_word;
            mem_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

endmodule

// File: tb/tb_ifq_fetch_ctrl.sv
// Directed bench for ifq_fetch_ctrl: line fetch/unpack, full stop, redirects, drain, latency,
// steady push+pop and reset. Expectations switch on IFQ_BYPASS_EN where behaviour differs.
module tb_ifq_fetch_ctrl;
    localparam int unsigned INST_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LINE_INSTS = 4;
    localparam int unsigned DEPTH      = 8;

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic                         cache_en;
    logic [ADDR_W-1:0]            cache_addr;
    logic                         cache_dout_valid = 1'b0;
    logic [LINE_INSTS*INST_W-1:0] cache_dout = '0;
    logic                         branch_valid = 1'b0;
    logic [ADDR_W-1:0]            branch_target = '0;
    logic                         rd_enable = 1'b0;
    logic [INST_W-1:0]            dout;
    logic [ADDR_W-1:0]            dout_pc;
    logic                         dout_valid;
    logic                         fifo_empty;
    logic                         fifo_full;

    int n_checks = 0;
    int n_errors = 0;

    ifq_fetch_ctrl #(
        .INST_W    (INST_W),
        .ADDR_W    (ADDR_W),
        .LINE_INSTS(LINE_INSTS),
        .DEPTH     (DEPTH),
        .RESET_PC  ('0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cache_en        (cache_en),
        .cache_addr      (cache_addr),
        .cache_dout_valid(cache_dout_valid),
        .cache_dout      (cache_dout),
        .branch_valid    (branch_valid),
        .branch_target   (branch_target),
        .rd_enable       (rd_enable),
        .dout            (dout),
        .dout_pc         (dout_pc),
        .dout_valid      (dout_valid),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return 32'hC0DE_0000 ^ addr;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] base);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) begin
            l[i*32 +: 32] = word_of(base + 32'(i * 4));
        end
        return l;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr);
        int n = 0;
        while (!cache_en && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_req_seen"}, 64'(cache_en), 64'd1);
        check_eq({tag, "_req_addr"}, 64'(cache_addr), 64'(addr));
    endtask

    // Returns in the first unpack cycle (T+1).
    task automatic serve_line(input string tag, input logic [31:0] addr, input int lat);
        wait_req(tag, addr);
        repeat (lat - 1) tick();
        cache_dout_valid = 1'b1;
        cache_dout       = line_of(addr);
        tick();
        cache_dout_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] pc);
        check_eq({tag, "_valid"}, 64'(dout_valid), 64'd1);
        check_eq({tag, "_pc"}, 64'(dout_pc), 64'(pc));
        check_eq({tag, "_dout"}, 64'(dout), 64'(word_of(pc)));
        rd_enable = 1'b1;
        tick();
        rd_enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_cache_en", 64'(cache_en), 64'd0);
        check_eq("rst_dout_valid", 64'(dout_valid), 64'd0);
        check_eq("rst_empty", 64'(fifo_empty), 64'd1);
        check_eq("rst_full", 64'(fifo_full), 64'd0);

        // Popping an empty FIFO through RST and IDLE must not underflow.
        reset     = 1'b0;
        rd_enable = 1'b1;
        tick();
        check_eq("idle_empty", 64'(fifo_empty), 64'd1);
        check_eq("idle_dout_valid", 64'(dout_valid), 64'd0);
        tick();
        check_eq("req_empty", 64'(fifo_empty), 64'd1);
        rd_enable = 1'b0;

        serve_line("l0", 32'h0, 3);
        repeat (4) tick();
        check_eq("l0_empty", 64'(fifo_empty), 64'd0);
        check_eq("l0_full", 64'(fifo_full), 64'd0);
        check_eq("l0_head_pc", 64'(dout_pc), 64'h0);
        serve_line("l1", 32'h10, 3);
        repeat (4) tick();
        check_eq("l1_full", 64'(fifo_full), 64'd1);
        repeat (5) tick();
        check_eq("full_no_req", 64'(cache_en), 64'd0);
        check_eq("full_hold", 64'(fifo_full), 64'd1);
        for (int i = 0; i < 4; i++) begin
            pop_check("pop", 32'(i * 4));
        end

        // Redirect mid-unpack with 5 entries, concurrent pop ignored.
        serve_line("l2", 32'h20, 2);
        tick();
        check_eq("l2_head_pc", 64'(dout_pc), 64'h10);
        check_eq("l2_full", 64'(fifo_full), 64'd0);
        branch_valid  = 1'b1;
        branch_target = 32'h108;
        rd_enable     = 1'b1;
        tick();
        branch_valid = 1'b0;
        rd_enable    = 1'b0;
        check_eq("br_empty", 64'(fifo_empty), 64'd1);
        check_eq("br_cache_en", 64'(cache_en), 64'd1);
        check_eq("br_addr", 64'(cache_addr), 64'h100);
        serve_line("l3", 32'h100, 2);
        tick();
        check_eq("l3_head_pc", 64'(dout_pc), 64'h108);
        tick();
        pop_check("br_pop0", 32'h108);
        pop_check("br_pop1", 32'h10C);
        check_eq("br_only2", 64'(fifo_empty), 64'd1);

        // Redirect while the request is outstanding; stale response two cycles later.
        wait_req("dr", 32'h110);
        branch_valid  = 1'b1;
        branch_target = 32'h200;
        tick();
        branch_valid = 1'b0;
        check_eq("dr_drain_en0", 64'(cache_en), 64'd0);
        tick();
        check_eq("dr_drain_en1", 64'(cache_en), 64'd0);
        cache_dout_valid = 1'b1;
        cache_dout       = line_of(32'h110);
        check_eq("dr_stale_en", 64'(cache_en), 64'd0);
        tick();
        cache_dout_valid = 1'b0;
        check_eq("dr_new_req", 64'(cache_en), 64'd1);
        check_eq("dr_new_addr", 64'(cache_addr), 64'h200);
        check_eq("dr_no_push0", 64'(fifo_empty), 64'd1);
        tick();
        check_eq("dr_no_push1", 64'(fifo_empty), 64'd1);

        // First-word latency into an empty FIFO.
        serve_line("lat", 32'h200, 3);
`ifdef IFQ_BYPASS_EN
        check_eq("lat_t1_valid", 64'(dout_valid), 64'd1);
        check_eq("lat_t1_pc", 64'(dout_pc), 64'h200);
        check_eq("lat_t1_dout", 64'(dout), 64'(word_of(32'h200)));
        rd_enable = 1'b1;
        tick();
        rd_enable = 1'b0;
        check_eq("lat_t2_empty", 64'(fifo_empty), 64'd1);
        check_eq("lat_t2_pc", 64'(dout_pc), 64'h204);
`else
        check_eq("lat_t1_valid", 64'(dout_valid), 64'd0);
        tick();
        check_eq("lat_t2_valid", 64'(dout_valid), 64'd1);
        check_eq("lat_t2_pc", 64'(dout_pc), 64'h200);
        check_eq("lat_t2_dout", 64'(dout), 64'(word_of(32'h200)));
`endif
        branch_valid  = 1'b1;
        branch_target = 32'h300;
        tick();
        branch_valid = 1'b0;
        check_eq("lat_flush_empty", 64'(fifo_empty), 64'd1);

        // Steady three entries while a line pushes under continuous pops.
        serve_line("st", 32'h300, 2);
        repeat (4) tick();
        pop_check("st_pop", 32'h300);
        serve_line("st2", 32'h310, 2);
        rd_enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_eq("st_flow_pc", 64'(dout_pc), 64'(32'h304 + 32'(k * 4)));
            check_eq("st_flow_dout", 64'(dout), 64'(word_of(32'h304 + 32'(k * 4))));
            tick();
        end
        rd_enable = 1'b0;
        check_eq("st_after_pc", 64'(dout_pc), 64'h314);
        pop_check("st_tail0", 32'h314);
        pop_check("st_tail1", 32'h318);
        pop_check("st_tail2", 32'h31C);
        check_eq("st_count3", 64'(fifo_empty), 64'd1);

        // Reset mid-operation; a response during reset is ignored.
        reset = 1'b1;
        tick();
        check_eq("rst2_cache_en", 64'(cache_en), 64'd0);
        check_eq("rst2_empty", 64'(fifo_empty), 64'd1);
        check_eq("rst2_dout_valid", 64'(dout_valid), 64'd0);
        cache_dout_valid = 1'b1;
        cache_dout       = line_of(32'h320);
        tick();
        cache_dout_valid = 1'b0;
        reset            = 1'b0;
        check_eq("rst2_no_push", 64'(fifo_empty), 64'd1);
        wait_req("rst2", 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
